// File: rtl/divider_8by4_seq_if.sv
// Handshake/data bundle for the sequential restoring divider.
//   start, dividend, divisor           : request side (driven by the master)
//   busy, done, quotient, remainder,
//   div_by_zero                        : result side (driven by the divider)
// Modports: master (requester / bench), slave (divider).
interface divider_8by4_seq_if #(
   parameter int DW = 8,
   parameter int VW = 4
);
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          busy;
   logic          done;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divider_8by4_seq.sv
// Sequential restoring divider: unsigned DW-bit dividend / VW-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    divider_8by4_seq_if.slave
//            start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; results held
// CALC    | one restoring step per cycle, DW cycles in total
// DONE    | one-cycle done pulse; results registered and valid
module divider_8by4_seq #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input logic               clk,
   input logic               rst_n,
   divider_8by4_seq_if.slave bus
);
   localparam int CW = $clog2(DW);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]    state;
   logic [DW-1:0] shift_q;
   logic [VW-1:0] dvsr_q;
   logic [VW:0]   part_q;
   logic [CW-1:0] count_q;
   logic [DW-1:0] quot_q;
   logic [VW-1:0] rem_q;
   logic          dbz_q;

   logic [VW:0]   part_shift;
   logic [VW:0]   part_diff;
   logic [VW:0]   part_next;
   logic          q_bit;
   logic [DW-1:0] shift_next;

   // One restoring step. The partial remainder is always below the divisor,
   // so its top bit is zero; it is still folded into the compare because a
   // set bit would be shifted out and mean the true value exceeds the divisor.
   always_comb begin
      part_shift = {part_q[VW-1:0], shift_q[DW-1]};
      part_diff  = part_shift - {1'b0, dvsr_q};
      q_bit      = part_q[VW] | (part_shift >= {1'b0, dvsr_q});
      part_next  = q_bit ? part_diff : part_shift;
      shift_next = {shift_q[DW-2:0], q_bit};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         shift_q <= '0;
         dvsr_q  <= '0;
         part_q  <= '0;
         count_q <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  shift_q <= bus.dividend;
                  dvsr_q  <= bus.divisor;
                  part_q  <= '0;
                  count_q <= '0;
                  if (bus.divisor == '0) begin
                     state  <= ST_DONE;
                     quot_q <= '1;
                     rem_q  <= '1;
                     dbz_q  <= 1'b1;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               shift_q <= shift_next;
               part_q  <= part_next;
               count_q <= count_q + CW'(1);
               // Results are published only on the transition into DONE so
               // they stay stable through IDLE and the whole calculation.
               if (count_q == CW'(DW - 1)) begin
                  state  <= ST_DONE;
                  quot_q <= shift_next;
                  rem_q  <= part_next[VW-1:0];
                  dbz_q  <= 1'b0;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy        = (state != ST_IDLE);
   assign bus.done        = (state == ST_DONE);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_8by4_seq.sv
// Self-checking bench for divider_8by4_seq: directed vectors with literal
// expectations, a cycle-level reference model, and a random sweep.
module tb_divider_8by4_seq;
   localparam int DW = 8;
   localparam int VW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   divider_8by4_seq_if #(.DW(DW), .VW(VW)) bus ();

   divider_8by4_seq #(.DW(DW), .VW(VW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: counts busy cycles left and publishes a/b, a%b when
   // the done cycle is entered.
   int     m_rem = 0;
   longint m_q = 0, m_r = 0;
   bit     m_dbz = 1'b0;
   longint m_a = 0, m_b = 0;
   longint p_a = 0, p_b = 0, p_q = 0, p_r = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem = 0;
         m_q   = 0;
         m_r   = 0;
         m_dbz = 1'b0;
      end else if (m_rem == 0) begin
         if (bus.start === 1'b1) begin
            p_a = bus.dividend;
            p_b = bus.divisor;
            if (p_b == 0) begin
               m_rem = 1;
               m_q   = (1 << DW) - 1;
               m_r   = (1 << VW) - 1;
               m_dbz = 1'b1;
               m_a   = p_a;
               m_b   = p_b;
            end else begin
               m_rem = DW + 1;
               p_q   = p_a / p_b;
               p_r   = p_a % p_b;
            end
         end
      end else begin
         m_rem--;
         if (m_rem == 1) begin
            m_q   = p_q;
            m_r   = p_r;
            m_dbz = 1'b0;
            m_a   = p_a;
            m_b   = p_b;
         end
      end
   end

   always @(negedge clk) begin
      cyc++;
      chk("busy", bus.busy, (m_rem != 0));
      chk("done", bus.done, (m_rem == 1));
      chk("quotient", bus.quotient, m_q);
      chk("remainder", bus.remainder, m_r);
      chk("div_by_zero", bus.div_by_zero, m_dbz);
      if (bus.done === 1'b1 && !m_dbz) begin
         chk("invariant", longint'(bus.quotient) * m_b + longint'(bus.remainder), m_a);
         chk("rem_lt_div", (longint'(bus.remainder) < m_b), 1);
      end
   end

   task automatic launch(input int a, input int b);
      @(negedge clk);
      #1;
      bus.dividend = DW'(a);
      bus.divisor  = VW'(b);
      bus.start    = 1'b1;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = ~DW'(a);
      bus.divisor  = ~VW'(b);
   endtask

   task automatic wait_done(input string name, output int k);
      bit seen;
      seen = 1'b0;
      k    = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         k++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      if (!seen) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic run(input string name, input int a, input int b, input int eq,
                      input int er, input int edbz, input int elat);
      int k;
      launch(a, b);
      wait_done(name, k);
      chk({name, "_latency"}, k, elat);
      chk({name, "_q"}, bus.quotient, eq);
      chk({name, "_r"}, bus.remainder, er);
      chk({name, "_dbz"}, bus.div_by_zero, edbz);
      @(negedge clk);
      chk({name, "_done_width"}, bus.done, 0);
   endtask

   initial begin
      int k;
      int t0, t1, t2;
      int a, b;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      #1 rst_n = 1'b0;
      #1;
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_q", bus.quotient, 0);
      chk("reset_r", bus.remainder, 0);
      chk("reset_dbz", bus.div_by_zero, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      run("6_3", 6, 3, 2, 0, 0, 9);
      run("16_4", 16, 4, 4, 0, 0, 9);
      run("14_2", 14, 2, 7, 0, 0, 9);
      run("225_15", 225, 15, 15, 0, 0, 9);
      run("1_1", 1, 1, 1, 0, 0, 9);
      run("200_7", 200, 7, 28, 4, 0, 9);
      run("255_1", 255, 1, 255, 0, 0, 9);
      run("0_9", 0, 9, 0, 0, 0, 9);
      run("7_15", 7, 15, 0, 7, 0, 9);
      run("255_15", 255, 15, 17, 0, 0, 9);
      run("37_0", 37, 0, 255, 15, 1, 1);
      run("9_3", 9, 3, 3, 0, 0, 9);

      // start pulsed during CALC must be ignored
      launch(50, 5);
      repeat (3) @(negedge clk);
      #1;
      bus.dividend = 8'd100;
      bus.divisor  = 4'd3;
      bus.start    = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done("ignore", k);
      chk("ignore_q", bus.quotient, 10);
      chk("ignore_r", bus.remainder, 0);
      repeat (12) @(negedge clk);
      chk("ignore_idle", bus.busy, 0);

      // start held high: back-to-back operations
      @(negedge clk);
      #1;
      bus.dividend = 8'd6;
      bus.divisor  = 4'd3;
      bus.start    = 1'b1;
      wait_done("held0", k);
      t0 = cyc;
      wait_done("held1", k);
      t1 = cyc;
      wait_done("held2", k);
      t2 = cyc;
      #1 bus.start = 1'b0;
      chk("held_spacing1", t1 - t0, DW + 2);
      chk("held_spacing2", t2 - t1, DW + 2);
      chk("held_q", bus.quotient, 2);
      repeat (3) @(negedge clk);

      // reset in the middle of a calculation
      launch(200, 7);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      chk("midrst_q", bus.quotient, 0);
      chk("midrst_r", bus.remainder, 0);
      chk("midrst_dbz", bus.div_by_zero, 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("midrst_no_done", bus.done, 0);
      run("after_rst_200_7", 200, 7, 28, 4, 0, 9);

      // random sweep, model-checked every cycle
      for (int i = 0; i < 1000; i++) begin
         a = $urandom_range(0, (1 << DW) - 1);
         b = $urandom_range(0, (1 << VW) - 1);
         launch(a, b);
         wait_done("random", k);
         chk("random_latency", k, (b == 0) ? 1 : DW + 1);
      end
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
